// File: rtl/byte_decode_stream.sv
// byte_decode_stream: ByteDecode_d stage, packed LSB-first bytes in,
// 256 D-bit coefficients out (mod q when D==12).
module byte_decode_stream #(
  parameter int D      = 12,
  parameter int Q      = 3329,
  parameter int N_COEF = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] coef,
  output logic        coef_reduced,
  output logic        coef_valid,
  input  logic        coef_ready,
  output logic        busy,
  output logic        done
);

  localparam int BW = D + 7;
  localparam logic [8:0] NBYTES = 9'(32 * D);
  localparam logic [8:0] LASTC  = 9'(N_COEF - 1);
  localparam logic [4:0] DW     = 5'(D);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [BW-1:0] bits_q;
  logic [4:0]    fill_q;
  logic [8:0]    byte_cnt_q;
  logic [8:0]    coef_cnt_q;

  logic          in_fire;
  logic          out_fire;
  logic [D-1:0]  raw;
  logic [11:0]   raw12;
  logic [12:0]   diff;
  logic          red;

  assign busy       = (state_q == S_BUSY);
  assign done       = (state_q == S_DONE);
  assign in_ready   = busy && (fill_q < DW)
                    && (byte_cnt_q < NBYTES);
  assign coef_valid = busy && (fill_q >= DW);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = coef_valid && coef_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_BUSY;
      S_BUSY: begin
        if (out_fire && coef_cnt_q == LASTC)
          state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bits above fill are always zero, so a new byte can be OR-ed in.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q     <= '0;
      fill_q     <= '0;
      byte_cnt_q <= '0;
      coef_cnt_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      bits_q     <= '0;
      fill_q     <= '0;
      byte_cnt_q <= '0;
      coef_cnt_q <= '0;
    end else if (in_fire) begin
      bits_q     <= bits_q | (BW'(in_byte) << fill_q);
      fill_q     <= fill_q + 5'd8;
      byte_cnt_q <= byte_cnt_q + 9'd1;
    end else if (out_fire) begin
      bits_q     <= bits_q >> D;
      fill_q     <= fill_q - DW;
      coef_cnt_q <= coef_cnt_q + 9'd1;
    end
  end

  // raw < 2Q for D==12, so one conditional subtract reduces fully.
  assign raw          = bits_q[D-1:0];
  assign raw12        = 12'(raw);
  assign diff         = {1'b0, raw12} - 13'(Q);
  assign red          = (D == 12) && !diff[12];
  assign coef         = red ? diff[11:0] : raw12;
  assign coef_reduced = red;

endmodule

// File: tb/tb_byte_decode_stream.sv
// tb_byte_decode_stream: vectors, corner sequences and a random full
// polynomial against a bit-level ByteDecode model.
module tb_byte_decode_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s12, iv12, ir12, cv12, cr12, crd12, b12, d12;
  logic [7:0]  ib12;
  logic [11:0] c12;
  logic        s1, iv1, ir1, cv1, cr1, crd1, b1, d1;
  logic [7:0]  ib1;
  logic [11:0] c1;

  byte_decode_stream #(.D(12)) u12 (
    .clk(clk), .rst(rst), .start(s12),
    .in_byte(ib12), .in_valid(iv12), .in_ready(ir12),
    .coef(c12), .coef_reduced(crd12), .coef_valid(cv12),
    .coef_ready(cr12), .busy(b12), .done(d12)
  );

  byte_decode_stream #(.D(1)) u1 (
    .clk(clk), .rst(rst), .start(s1),
    .in_byte(ib1), .in_valid(iv1), .in_ready(ir1),
    .coef(c1), .coef_reduced(crd1), .coef_valid(cv1),
    .coef_ready(cr1), .busy(b1), .done(d1)
  );

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    nvec++;
    nbad++;
    $display("FAIL %s: timeout, got no handshake, want one", nm);
  endtask

  task automatic push(input int inst, input logic [7:0] b);
    logic ok;
    if (inst == 12) begin ib12 = b; iv12 = 1'b1; end
    else begin ib1 = b; iv1 = 1'b1; end
    for (int k = 0; k < 40; k++) begin
      ok = (inst == 12) ? ir12 : ir1;
      @(posedge clk); #1;
      if (ok) begin
        iv12 = 1'b0;
        iv1  = 1'b0;
        return;
      end
    end
    iv12 = 1'b0;
    iv1  = 1'b0;
    tmo("push");
  endtask

  task automatic pop(input int inst, output int c, output int r);
    logic v;
    c = -1;
    r = -1;
    if (inst == 12) cr12 = 1'b1; else cr1 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      v = (inst == 12) ? cv12 : cv1;
      if (v) begin
        c = (inst == 12) ? int'(c12) : int'(c1);
        r = (inst == 12) ? int'(crd12) : int'(crd1);
        @(posedge clk); #1;
        cr12 = 1'b0;
        cr1  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    cr12 = 1'b0;
    cr1  = 1'b0;
    tmo("pop");
  endtask

  task automatic do_start(input int inst);
    if (inst == 12) s12 = 1'b1; else s1 = 1'b1;
    @(posedge clk); #1;
    s12 = 1'b0;
    s1  = 1'b0;
    chk("start_busy", (inst == 12) ? int'(b12) : int'(b1), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reference: coefficient k is bits 12k..12k+11 of the LSB-first stream.
  logic [7:0] pb [384];

  function automatic int model12(input int k);
    int v = 0;
    int m;
    for (int j = 0; j < 12; j++) begin
      m = 12 * k + j;
      v = v | (((int'(pb[m / 8]) >> (m % 8)) & 1) << j);
    end
    return v;
  endfunction

  typedef struct {
    logic [7:0] b0, b1, b2;
    int c0, r0, c1, r1;
  } vec_t;

  vec_t tv [6];

  int c, r, got, extra, early;
  bit fin, hs;
  int raw_e;

  initial begin
    tv[0] = '{8'h01, 8'h23, 8'h45, 769, 0, 1106, 0};
    tv[1] = '{8'hFF, 8'hFF, 8'hFF, 766, 1, 766, 1};
    tv[2] = '{8'h01, 8'hDD, 8'h00, 0, 1, 13, 0};
    tv[3] = '{8'h00, 8'h0D, 8'h0D, 3328, 0, 208, 0};
    tv[4] = '{8'h00, 8'hD1, 8'hD0, 256, 0, 12, 1};
    tv[5] = '{8'h00, 8'h00, 8'h00, 0, 0, 0, 0};

    rst = 1'b1;
    {s12, iv12, cr12, s1, iv1, cr1} = '0;
    ib12 = '0;
    ib1  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(b12), 0);
    chk("rst_done", int'(d12), 0);
    chk("rst_cvalid", int'(cv12), 0);
    chk("rst_iready", int'(ir12), 0);
    chk("rst_coef", int'(c12), 0);
    chk("rst_busy_d1", int'(b1), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_start(12);
    for (int i = 0; i < 6; i++) begin
      push(12, tv[i].b0);
      push(12, tv[i].b1);
      chk("lat_valid", int'(cv12), 1);
      pop(12, c, r);
      chk("tv_c0", c, tv[i].c0);
      chk("tv_r0", r, tv[i].r0);
      push(12, tv[i].b2);
      pop(12, c, r);
      chk("tv_c1", c, tv[i].c1);
      chk("tv_r1", r, tv[i].r1);
    end

    do_start(1);
    push(1, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      pop(1, c, r);
      chk("d1_coef", c, (8'hA5 >> i) & 1);
      chk("d1_red", r, 0);
    end
    chk("d1_iready", int'(ir1), 1);

    // Backpressure hold
    do_reset();
    do_start(12);
    push(12, 8'h01);
    push(12, 8'h23);
    cr12 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(cv12), 1);
      chk("bp_coef", int'(c12), 769);
      chk("bp_iready", int'(ir12), 0);
      @(posedge clk); #1;
    end
    pop(12, c, r);
    chk("bp_c0", c, 769);
    chk("bp_nodup", int'(cv12), 0);
    push(12, 8'h45);
    pop(12, c, r);
    chk("bp_c1", c, 1106);
    chk("bp_empty", int'(cv12), 0);

    // Full polynomial, random gaps
    for (int i = 0; i < 384; i++) pb[i] = 8'(i);
    do_reset();
    do_start(12);
    got   = 0;
    extra = 0;
    early = 0;
    fin   = 0;
    fork
      begin
        int i = 0;
        for (int cyc = 0; cyc < 8000 && i < 384; cyc++) begin
          iv12 = ($urandom % 4) != 0;
          ib12 = pb[i];
          if (iv12 && ir12) i++;
          @(posedge clk); #1;
        end
        if (i != 384) tmo("full_bytes");
        iv12 = 1'b1;
        ib12 = 8'hAA;
        for (int k = 0; k < 30; k++) begin
          if (ir12) extra++;
          @(posedge clk); #1;
        end
        iv12 = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 8000 && !fin; cyc++) begin
          cr12 = ($urandom % 4) != 0;
          hs = cv12 && cr12;
          if (hs) begin
            raw_e = model12(got);
            chk("full_coef", int'(c12),
                raw_e >= 3329 ? raw_e - 3329 : raw_e);
            chk("full_red", int'(crd12), raw_e >= 3329 ? 1 : 0);
            got++;
          end
          @(posedge clk); #1;
          if (hs && got == 256) begin
            chk("done_pulse", int'(d12), 1);
            chk("done_busy", int'(b12), 0);
            @(posedge clk); #1;
            chk("done_single", int'(d12), 0);
            fin = 1;
          end else if (d12) begin
            early++;
          end
        end
        cr12 = 1'b0;
      end
      begin
        repeat (60) @(posedge clk);
        #1;
        s12 = 1'b1;
        @(posedge clk); #1;
        s12 = 1'b0;
      end
    join
    chk("full_count", got, 256);
    chk("full_extra_byte", extra, 0);
    chk("full_early_done", early, 0);

    // Reset mid-polynomial
    do_start(12);
    cr12 = 1'b1;
    for (int i = 0; i < 100; i++) push(12, 8'(i * 7));
    chk("mid_busy_pre", int'(b12), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cr12 = 1'b0;
    chk("mid_busy", int'(b12), 0);
    chk("mid_cvalid", int'(cv12), 0);
    chk("mid_iready", int'(ir12), 0);
    @(posedge clk); #1;
    chk("mid_nodone", int'(d12), 0);
    do_start(12);
    push(12, 8'h01);
    push(12, 8'h23);
    pop(12, c, r);
    chk("mid_c0", c, 769);
    push(12, 8'h45);
    pop(12, c, r);
    chk("mid_c1", c, 1106);
    chk("mid_r1", r, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
